// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - rv32 instruction fetch stage with skid buffer and redirect handling
//
// Owns the program counter, issues word fetches over a req/ack handshake and
// presents returned instructions to the decoder.
//
// Ports:
//   clk            system clock, rising edge
//   nrst           asynchronous active-low reset
//   stall          decoder cannot accept the presented instruction this cycle
//   branch_taken   redirect request from execute
//   branch_target  redirect address (bits [1:0] forced to 0)
//   imem_ack       memory returns data this cycle (only meaningful while imem_req=1)
//   imem_rdata     instruction word, valid with imem_ack
//   imem_req       fetch request, held with imem_addr stable until imem_ack
//   imem_addr      word-aligned fetch address (always the current pc)
//   inst_valid     opcode/instruction/pc_out hold a valid instruction
//   opcode         instruction bits [6:0]
//   instruction    instruction bits [31:7]
//   pc_out         address of the presented instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        inst_valid,
  output logic [6:0]  opcode,
  output logic [24:0] instruction,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_target, pend_target_n;
  logic [31:0] out_reg, out_reg_n;
  logic [31:0] out_pc, out_pc_n;
  logic [31:0] skid_reg, skid_reg_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        valid, valid_n;

  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        occupied;

  // Masking keeps every bit of branch_target in use while forcing word alignment.
  assign target   = branch_target & 32'hFFFF_FFFC;
  // 32-bit add wraps naturally from 0xFFFF_FFFC to 0.
  assign pc_inc   = pc + 32'd4;
  // The presented instruction is still waiting for the decoder.
  assign occupied = valid & stall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_target <= 32'h0;
      out_reg     <= 32'h0;
      out_pc      <= 32'h0;
      skid_reg    <= 32'h0;
      skid_pc     <= 32'h0;
      valid       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_target <= pend_target_n;
      out_reg     <= out_reg_n;
      out_pc      <= out_pc_n;
      skid_reg    <= skid_reg_n;
      skid_pc     <= skid_pc_n;
      valid       <= valid_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_target_n = pend_target;
    out_reg_n     = out_reg;
    out_pc_n      = out_pc;
    skid_reg_n    = skid_reg;
    skid_pc_n     = skid_pc;
    valid_n       = valid;

    unique case (state)
      IDLE: begin
        state_n = FETCH;
      end

      FETCH: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          if (imem_ack) begin
            // Returned word belongs to the wrong path; restart at the target.
            pc_n = target;
          end else begin
            // Request must complete at the old address before redirecting.
            pend_target_n = target;
            state_n       = DRAIN;
          end
        end else if (imem_ack && !occupied) begin
          out_reg_n = imem_rdata;
          out_pc_n  = pc;
          valid_n   = 1'b1;
          pc_n      = pc_inc;
        end else if (imem_ack) begin
          // Output is blocked; park the new word and stop requesting.
          skid_reg_n = imem_rdata;
          skid_pc_n  = pc;
          pc_n       = pc_inc;
          state_n    = HOLD;
        end else if (valid && !stall) begin
          valid_n = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          pc_n    = target;
          state_n = FETCH;
        end else if (!stall) begin
          out_reg_n = skid_reg;
          out_pc_n  = skid_pc;
          valid_n   = 1'b1;
          state_n   = FETCH;
        end
      end

      DRAIN: begin
        valid_n = 1'b0;
        if (branch_taken) begin
          pend_target_n = target;
        end
        if (imem_ack) begin
          // The most recent redirect wins, even when it lands with the ack.
          pc_n    = branch_taken ? target : pend_target;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = pc;
  assign inst_valid  = valid;
  assign opcode      = out_reg[6:0];
  assign instruction = out_reg[31:7];
  assign pc_out      = out_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [6:0]  opcode;
  logic [24:0] instruction;
  logic [31:0] pc_out;

  int total = 0;
  int bad   = 0;

  // Each entry: {pc, instruction word} expected to be consumed by the decoder.
  logic [63:0] sb_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .inst_valid   (inst_valid),
    .opcode       (opcode),
    .instruction  (instruction),
    .pc_out       (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; a redirect flushes everything not yet consumed.
  task automatic drive(input logic st, input logic ack, input logic [31:0] rd,
                       input logic br, input logic [31:0] tg);
    stall         = st;
    imem_ack      = ack;
    imem_rdata    = rd;
    branch_taken  = br;
    branch_target = tg;
    if (br) sb_q.delete();
  endtask

  task automatic expect_word(input logic [31:0] word, input logic [31:0] pc);
    sb_q.push_back({pc, word});
  endtask

  // Decoder consumes the presented instruction when valid, not stalled and not flushed.
  always @(negedge clk) begin
    logic [63:0] e;
    if (nrst && inst_valid && !stall && !branch_taken) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_word", {instruction, opcode}, e[31:0]);
        check_eq("sb_pc", pc_out, e[63:32]);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_pc_out", pc_out, 0);
    check_eq("rst_addr", imem_addr, 32'h100);

    // First fetch
    nrst = 1'b1;
    check_eq("idle_req", imem_req, 0);
    tick();
    check_eq("fetch_req", imem_req, 1);
    check_eq("fetch_addr", imem_addr, 32'h100);
    drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
    expect_word(32'h0050_0093, 32'h100);
    tick();
    check_eq("first_valid", inst_valid, 1);
    check_eq("first_opcode", opcode, 32'h13);
    check_eq("first_instr", instruction, 32'h000A001);
    check_eq("first_pc", pc_out, 32'h100);
    check_eq("first_addr", imem_addr, 32'h104);

    // Zero-wait streaming
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w;
      w = 32'h11 * (i + 1);
      drive(1'b0, 1'b1, w, 1'b0, 32'h0);
      expect_word(w, 32'h104 + 32'(4 * i));
      tick();
      check_eq("stream_valid", inst_valid, 1);
      check_eq("stream_pc", pc_out, 32'h104 + 32'(4 * i));
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_eq("stream_end_valid", inst_valid, 0);

    // Stall and skid
    drive(1'b0, 1'b1, 32'h0000_0044, 1'b0, 32'h0);
    expect_word(32'h44, 32'h110);
    tick();
    drive(1'b1, 1'b1, 32'hAAAA_0013, 1'b0, 32'h0);
    expect_word(32'hAAAA_0013, 32'h114);
    tick();
    check_eq("hold_req", imem_req, 0);
    check_eq("hold_pc", pc_out, 32'h110);
    check_eq("hold_opcode", opcode, 32'h44);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_eq("hold2_req", imem_req, 0);
    check_eq("hold2_valid", inst_valid, 1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_eq("unskid_pc", pc_out, 32'h114);
    check_eq("unskid_opcode", opcode, 32'h13);
    check_eq("unskid_req", imem_req, 1);
    check_eq("unskid_addr", imem_addr, 32'h118);
    tick();
    check_eq("unskid_drop", inst_valid, 0);

    // Redirect coincident with ack, flushing a presented instruction
    drive(1'b0, 1'b1, 32'h0000_0055, 1'b0, 32'h0);
    expect_word(32'h55, 32'h118);
    tick();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0203);
    tick();
    check_eq("coinc_valid", inst_valid, 0);
    check_eq("coinc_addr", imem_addr, 32'h200);
    check_eq("coinc_req", imem_req, 1);

    // Redirect while request outstanding
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0403);
    tick();
    check_eq("drain_addr", imem_addr, 32'h200);
    check_eq("drain_req", imem_req, 1);
    check_eq("drain_valid", inst_valid, 0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_eq("drain_wait_addr", imem_addr, 32'h200);
    drive(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 32'h0);
    tick();
    check_eq("drain_done_addr", imem_addr, 32'h400);
    check_eq("drain_done_valid", inst_valid, 0);

    // Latest redirect wins in DRAIN, including with the ack
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h600);
    tick();
    drive(1'b0, 1'b1, 32'hBAD0_0002, 1'b1, 32'h700);
    tick();
    check_eq("drain_latest_addr", imem_addr, 32'h700);

    // Branch during HOLD drops skid and output
    drive(1'b0, 1'b1, 32'h0000_0066, 1'b0, 32'h0);
    expect_word(32'h66, 32'h700);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0077, 1'b0, 32'h0);
    expect_word(32'h77, 32'h704);
    tick();
    check_eq("hb_hold_req", imem_req, 0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h800);
    tick();
    check_eq("hb_valid", inst_valid, 0);
    check_eq("hb_req", imem_req, 1);
    check_eq("hb_addr", imem_addr, 32'h800);
    drive(1'b0, 1'b1, 32'h0000_0088, 1'b0, 32'h0);
    expect_word(32'h88, 32'h800);
    tick();
    check_eq("hb_after_pc", pc_out, 32'h800);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // PC wrap
    drive(1'b0, 1'b1, 32'hBAD0_0003, 1'b1, 32'hFFFF_FFFF);
    tick();
    check_eq("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 32'h0000_0099, 1'b0, 32'h0);
    expect_word(32'h99, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // Async reset mid-DRAIN, away from any clock edge
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h900);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    nrst = 1'b0;
    sb_q.delete();
    #1;
    check_eq("arst_req", imem_req, 0);
    check_eq("arst_valid", inst_valid, 0);
    check_eq("arst_pc_out", pc_out, 0);
    check_eq("arst_word", {instruction, opcode}, 0);
    check_eq("arst_addr", imem_addr, 32'h100);
    tick();
    drive(1'b0, 1'b1, 32'hBAD0_0004, 1'b0, 32'h0);
    nrst = 1'b1;
    tick();
    check_eq("post_rst_valid", inst_valid, 0);
    check_eq("post_rst_addr", imem_addr, 32'h100);
    check_eq("post_rst_req", imem_req, 1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    check_eq("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the decoder in the rv32 pipeline.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Captures returned instructions into an output register and presents them to the decoder, split as opcode and the upper 25 bits.
- Handles downstream stall with a one-entry skid buffer, and handles branch/jump redirects, including redirects that arrive while a request is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous, active-low reset.
- stall  input  1  decoder/pipeline cannot accept the current instruction this cycle.
- branch_taken  input  1  redirect request from execute stage.
- branch_target  input  32  redirect address; bits [1:0] are ignored and forced to 0.
- imem_ack  input  1  memory has returned data this cycle; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- imem_req  output  1  fetch request; held high with imem_addr stable until imem_ack.
- imem_addr  output  32  fetch address (word aligned).
- inst_valid  output  1  opcode/instruction/pc_out hold a valid instruction.
- opcode  output  7  instruction bits [6:0].
- instruction  output  25  instruction bits [31:7].
- pc_out  output  32  address of the presented instruction.

Behaviour:
- Registers: pc, pend_target, out_reg(32), out_pc, skid_reg(32), skid_pc, state.
- States: IDLE, FETCH, HOLD, DRAIN.
- Reset (async, nrst=0): state=IDLE, pc=RESET_PC, inst_valid=0, imem_req=0, out_reg=0, out_pc=0, skid_reg=0, skid_pc=0, pend_target=0.
- imem_req is 1 in FETCH and DRAIN, and 0 in IDLE and HOLD.
- imem_addr = pc in all states.
- "occupied" = inst_valid & stall.
- IDLE:
  - Always goes to FETCH on the next cycle.
- FETCH:
  - branch_taken=1 (highest priority): inst_valid<=0.
    - If imem_ack=1: discard imem_rdata, pc<=target, stay in FETCH.
    - If imem_ack=0: pend_target<=target, go to DRAIN. pc is unchanged so imem_addr stays stable.
  - ack, not occupied: out_reg<=rdata, out_pc<=pc, inst_valid<=1, pc<=pc+4, stay in FETCH.
  - ack, occupied: skid_reg<=rdata, skid_pc<=pc, pc<=pc+4, go to HOLD. The output register is unchanged.
  - no ack: if inst_valid & !stall, inst_valid<=0.
- HOLD (req=0):
  - branch_taken=1: drop skid and output, inst_valid<=0, pc<=target, go to FETCH.
  - stall=0: out_reg<=skid_reg, out_pc<=skid_pc, inst_valid stays 1, go to FETCH.
  - stall=1: no change.
- DRAIN (req=1, addr=old pc):
  - Every cycle: inst_valid<=0.
  - branch_taken=1: pend_target<=new target. The latest redirect wins, including when it coincides with ack.
  - On ack: discard rdata, pc<=(branch_taken ? target : pend_target), go to FETCH.
- Latency: instruction visible on inst_valid one cycle after the ack cycle. Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle when there is no stall.
- branch_taken overrides stall in every state. A flushed instruction is never presented.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset asserted mid-operation, in any state, returns immediately to the reset values. Any in-flight memory response after reset is ignored because imem_req=0.
- opcode = out_reg[6:0]; instruction = out_reg[31:7].

Test Plan:
- Reset/first fetch, RESET_PC=32'h100:
  - Release nrst; one IDLE cycle, then imem_req=1, imem_addr=0x100.
  - Ack with 32'h00500093: next cycle inst_valid=1, opcode=7'h13, instruction=25'h000A001, pc_out=0x100, imem_addr=0x104.
- Zero-wait streaming:
  - ack held high, stall=0, words 0x11,0x22,0x33 -> inst_valid=1 on 3 consecutive cycles with pc_out 0x100, 0x104, 0x108.
- Stall/skid:
  - inst_valid=1 with stall=1; ack arrives with 0xAAAA_0013 -> state HOLD, imem_req=0, output unchanged.
  - Drop stall -> output becomes 0xAAAA_0013 next cycle, then req resumes at the following address.
- Redirect with outstanding request:
  - Request at 0x200 not yet acked; branch_taken=1, target=0x403 -> DRAIN, imem_addr stays 0x200, inst_valid=0.
  - Ack 2 cycles later: data discarded, next imem_addr=0x400.
- Redirect coincident with ack in FETCH:
  - rdata discarded, inst_valid=0, next imem_addr=target.
  - Branch during HOLD: skid dropped, FETCH at target.
- Wrap and async reset:
  - pc=0xFFFF_FFFC acked -> next imem_addr=0x0.
  - Assert nrst mid-DRAIN -> outputs zero and imem_req=0 immediately, without waiting for clk.
